// File: rtl/ysyx_22040759_ifu_fq_pkg.sv
// Shared constants and helpers for the fetch unit and its FIFOs.
package ysyx_22040759_ifu_fq_pkg;

  // Canonical RISC-V NOP (addi x0, x0, 0), shown when the queue is empty.
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Default PC loaded on reset.
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

  // Pointer width for a FIFO of the given depth; at least one bit so
  // that depth-1 FIFOs still have a legal pointer register.
  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/ysyx_22040759_sync_fifo.sv
// Show-ahead synchronous FIFO with a synchronous flush.
// head_data always presents the oldest entry; push is ignored when full,
// pop is ignored when empty, and flush voids any same-cycle push or pop.
module ysyx_22040759_sync_fifo
  import ysyx_22040759_ifu_fq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int PTR_W = ptr_width(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (count_reg == CNT_W'(DEPTH));
  assign empty     = (count_reg == '0);
  assign count     = count_reg;
  assign do_push   = push && !full && !flush;
  assign do_pop    = pop && !empty && !flush;
  assign head_data = mem[rd_ptr_reg];

  // Storage array: written on accepted pushes only, never reset.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the FIFO in one edge.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= next_ptr(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/ysyx_22040759_ifu_fq.sv
// Instruction-fetch unit with a decoupling fetch queue.
// Requests are issued only when a queue slot is guaranteed for the
// response (credit = queued entries + live outstanding requests), so the
// queue can never overflow. A redirect flushes the queue and marks every
// request still in flight as dead; their responses are dropped in order.
module ysyx_22040759_ifu_fq
  import ysyx_22040759_ifu_fq_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              ADDR_W   = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC),
  parameter int              FQ_DEPTH = 4,
  parameter int              MAX_OUT  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  input  logic              stall,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              rsp_valid,
  input  logic [63:0]       rsp_data,
  output logic              ds_valid,
  input  logic              ds_ready,
  output logic [31:0]       ds_inst,
  output logic [XLEN-1:0]   ds_pc
);

  localparam int IF_W  = $clog2(MAX_OUT + 1);
  localparam int FQ_CW = $clog2(FQ_DEPTH + 1);
  localparam int CR_W  = $clog2(FQ_DEPTH + MAX_OUT + 1) + 1;
  localparam int ENT_W = 32 + XLEN;

  logic [XLEN-1:0]  fetch_pc_reg, fetch_pc_next;
  logic [IF_W-1:0]  inflight_reg, inflight_next;
  logic [IF_W-1:0]  drop_cnt_reg, drop_cnt_next;
  logic [IF_W-1:0]  live;
  logic [CR_W-1:0]  credit_used;
  logic [XLEN-1:0]  redirect_target;
  logic             req_fire;
  logic             rsp_drop;
  logic             fq_push;
  logic             fq_pop;
  logic [31:0]      rsp_inst;
  logic [ENT_W-1:0] fq_push_data;
  logic [ENT_W-1:0] fq_head;
  logic [FQ_CW-1:0] fq_count;
  logic             fq_full, fq_empty;
  logic [XLEN-1:0]  tag_pc;
  logic [IF_W-1:0]  tag_count;
  logic             tag_full, tag_empty;

  // Request gating, response routing and next-state for counters / PC.
  always_comb begin
    live            = inflight_reg - drop_cnt_reg;
    credit_used     = CR_W'(fq_count) + CR_W'(live);
    req_valid       = !rst && !stall && !redirect_valid
                      && (inflight_reg < IF_W'(MAX_OUT))
                      && (credit_used < CR_W'(FQ_DEPTH));
    req_fire        = req_valid && req_ready;
    redirect_target = redirect_pc & ~XLEN'(3);

    rsp_drop     = (drop_cnt_reg != '0) || redirect_valid;
    fq_push      = rsp_valid && !rsp_drop;
    rsp_inst     = tag_pc[2] ? rsp_data[63:32] : rsp_data[31:0];
    fq_push_data = {rsp_inst, tag_pc};
    fq_pop       = !fq_empty && ds_ready;

    inflight_next = inflight_reg + IF_W'(req_fire) - IF_W'(rsp_valid);

    if (redirect_valid) begin
      drop_cnt_next = inflight_next;
    end else if (rsp_valid && (drop_cnt_reg != '0)) begin
      drop_cnt_next = drop_cnt_reg - 1'b1;
    end else begin
      drop_cnt_next = drop_cnt_reg;
    end

    if (redirect_valid) begin
      fetch_pc_next = redirect_target;
    end else if (req_fire) begin
      fetch_pc_next = fetch_pc_reg + XLEN'(4);
    end else begin
      fetch_pc_next = fetch_pc_reg;
    end
  end

  // Fetch PC and in-flight / drop counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_reg <= RESET_PC;
      inflight_reg <= '0;
      drop_cnt_reg <= '0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      inflight_reg <= inflight_next;
      drop_cnt_reg <= drop_cnt_next;
    end
  end

  assign req_addr = fetch_pc_reg[ADDR_W-1:0];

  // Tags stay aligned with bus responses, so this FIFO is never flushed.
  ysyx_22040759_sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (MAX_OUT)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data (fetch_pc_reg),
    .pop       (rsp_valid),
    .head_data (tag_pc),
    .count     (tag_count),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  ysyx_22040759_sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (fq_push),
    .push_data (fq_push_data),
    .pop       (fq_pop),
    .head_data (fq_head),
    .count     (fq_count),
    .full      (fq_full),
    .empty     (fq_empty)
  );

  assign ds_valid = !fq_empty;
  assign ds_inst  = fq_empty ? NOP_INST : fq_head[ENT_W-1:XLEN];
  assign ds_pc    = fq_empty ? '0 : fq_head[XLEN-1:0];

`ifndef SYNTHESIS
  // Invariants implied by the credit rule and in-order bus responses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(fq_push && fq_full));
      assert (!(rsp_valid && tag_empty));
      assert (!(req_fire && tag_full));
      assert (tag_count == inflight_reg);
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22040759_ifu_fq.sv
// Randomized bench for the fetch unit. The reference model tracks each
// outstanding request as {pc, dead} and the queue as a list of
// {inst, pc}; a redirect kills every request still outstanding.
module tb_ysyx_22040759_ifu_fq;

  localparam int          XLEN     = 64;
  localparam int          ADDR_W   = 32;
  localparam int          FQ_DEPTH = 4;
  localparam int          MAX_OUT  = 2;
  localparam logic [63:0] RST_PC   = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        stall;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [63:0] rsp_data;
  logic        ds_valid;
  logic        ds_ready;
  logic [31:0] ds_inst;
  logic [63:0] ds_pc;

  always #5 clk = ~clk;

  ysyx_22040759_ifu_fq #(
    .XLEN     (XLEN),
    .ADDR_W   (ADDR_W),
    .RESET_PC (RST_PC),
    .FQ_DEPTH (FQ_DEPTH),
    .MAX_OUT  (MAX_OUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .ds_valid       (ds_valid),
    .ds_ready       (ds_ready),
    .ds_inst        (ds_inst),
    .ds_pc          (ds_pc)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int dmode       = 0;

  // Reference model state
  logic [63:0] m_pc;
  logic [63:0] m_opc[$];
  bit          m_dead[$];
  logic [31:0] m_finst[$];
  logic [63:0] m_fpc[$];

  // Bus model state
  int          bus_cyc[$];
  logic [31:0] bus_addr[$];

  // Values captured between the check point and the next edge
  bit s_exp_rv;
  bit s_bus_hs;
  logic [31:0] s_addr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] hashw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Instruction memory seen by the model: one word per 4-byte PC.
  function automatic logic [31:0] mem_inst(input logic [63:0] pc);
    if (dmode == 0) return pc[2] ? 32'h0000_0093 : 32'h0000_0013;
    return hashw({pc[31:2], 2'b00});
  endfunction

  // Bus returns the aligned doubleword holding the requested address.
  function automatic logic [63:0] bus_dword(input logic [31:0] addr);
    logic [31:0] dw;
    dw = {addr[31:3], 3'b000};
    if (dmode == 0) return {32'h0000_0093, 32'h0000_0013};
    return {hashw(dw + 32'd4), hashw(dw)};
  endfunction

  function automatic bit model_req_valid();
    int live;
    live = 0;
    foreach (m_dead[i]) if (!m_dead[i]) live++;
    return !rst && !stall && !redirect_valid
           && (m_opc.size() < MAX_OUT)
           && (m_fpc.size() + live < FQ_DEPTH);
  endfunction

  task automatic model_edge();
    logic [63:0] rpc;
    bit          rdead;
    bit          have_push;
    have_push = 0;
    rpc = '0;
    if (rst) begin
      m_pc = RST_PC;
      m_opc.delete();
      m_dead.delete();
      m_finst.delete();
      m_fpc.delete();
      bus_cyc.delete();
      bus_addr.delete();
      return;
    end
    if (rsp_valid && m_opc.size() > 0) begin
      rpc   = m_opc.pop_front();
      rdead = m_dead.pop_front();
      have_push = !rdead && !redirect_valid;
    end
    if (m_fpc.size() > 0 && ds_ready) begin
      void'(m_fpc.pop_front());
      void'(m_finst.pop_front());
    end
    if (have_push) begin
      m_finst.push_back(mem_inst(rpc));
      m_fpc.push_back(rpc);
    end
    if (s_exp_rv && req_ready) begin
      m_opc.push_back(m_pc);
      m_dead.push_back(1'b0);
      m_pc = m_pc + 64'd4;
    end
    if (redirect_valid) begin
      m_finst.delete();
      m_fpc.delete();
      foreach (m_dead[i]) m_dead[i] = 1'b1;
      m_pc = {redirect_pc[63:2], 2'b00};
    end
    // Bus side, driven by what the DUT actually handshook.
    if (rsp_valid && bus_cyc.size() > 0) begin
      void'(bus_cyc.pop_front());
      void'(bus_addr.pop_front());
    end
    if (s_bus_hs) begin
      bus_cyc.push_back(cyc);
      bus_addr.push_back(s_addr);
    end
  endtask

  // Probabilities in percent except p_rst, which is per mille.
  task automatic run(input int n, input int p_rdy, input int p_rsp, input int p_ds,
                     input int p_stall, input int p_redir, input int p_rst, input int mode);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cyc++;
      dmode     = mode;
      rst       = ($urandom_range(0, 999) < p_rst);
      req_ready = ($urandom_range(0, 99) < p_rdy);
      ds_ready  = ($urandom_range(0, 99) < p_ds);
      stall     = ($urandom_range(0, 99) < p_stall);
      redirect_valid = ($urandom_range(0, 99) < p_redir);
      if ($urandom_range(0, 1) == 0)
        redirect_pc = {32'h0, 32'h8000_1000 | 32'($urandom_range(0, 255))};
      else
        redirect_pc = {$urandom, $urandom};
      rsp_valid = 1'b0;
      rsp_data  = {$urandom, $urandom};
      if (!rst && bus_cyc.size() > 0 && bus_cyc[0] < cyc && $urandom_range(0, 99) < p_rsp) begin
        rsp_valid = 1'b1;
        rsp_data  = bus_dword(bus_addr[0]);
      end
      #1;
      s_exp_rv = model_req_valid();
      s_bus_hs = req_valid && req_ready;
      s_addr   = req_addr;
      chk("req_valid", {63'b0, req_valid}, {63'b0, s_exp_rv});
      if (s_exp_rv) chk("req_addr", {32'b0, req_addr}, {32'b0, m_pc[31:0]});
      chk("ds_valid", {63'b0, ds_valid}, {63'b0, m_fpc.size() > 0});
      chk("ds_inst", {32'b0, ds_inst}, {32'b0, (m_fpc.size() > 0) ? m_finst[0] : 32'h13});
      chk("ds_pc", ds_pc, (m_fpc.size() > 0) ? m_fpc[0] : 64'h0);
      @(posedge clk);
      model_edge();
    end
  endtask

  initial begin
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    stall = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_data = '0;
    ds_ready = 1'b0;
    s_exp_rv = 1'b0;
    s_bus_hs = 1'b0;
    s_addr = '0;
    @(posedge clk);
    model_edge();

    //  n    rdy  rsp  ds  stall redir rst  mode
    run(2,   100, 100, 100, 0,   0,    1000, 0);   // reset held
    run(20,  100, 100, 100, 0,   0,    0,    0);   // streaming fetch
    run(14,  100, 100, 0,   0,   0,    0,    0);   // decode blocked: queue fills
    run(14,  100, 100, 100, 0,   0,    0,    0);   // drain then resume
    run(60,  100, 50,  80,  0,   25,   0,    1);   // redirects with traffic in flight
    run(40,  100, 30,  100, 80,  0,    0,    1);   // heavy stall
    run(600, 70,  60,  70,  10,  4,    3,    1);   // mixed random
    run(400, 100, 100, 60,  5,   15,   5,    1);   // fast bus, many redirects
    run(300, 50,  40,  40,  30,  8,    8,    1);   // slow everything
    run(3,   100, 100, 100, 0,   0,    1000, 1);   // final reset

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ysyx_22040759_ifu_fq.md
# ysyx_22040759_ifu_fq

Parametrised instruction-fetch unit with a decoupling fetch queue. It sits between the PC/redirect logic and decode. It issues up to `MAX_OUT` pipelined fetch requests on a split request/response bus and buffers returned instructions in a `FQ_DEPTH`-entry queue. On redirect it flushes the queue and silently discards responses that were already in flight.

## Interface
Parameters:
- `XLEN`, 64, PC width.
- `ADDR_W`, 32, bus address width; `req_addr = fetch_pc[ADDR_W-1:0]`.
- `RESET_PC`, 64'h8000_0000, PC after reset.
- `FQ_DEPTH`, 4, fetch-queue entries; power of 2, ≥2.
- `MAX_OUT`, 2, maximum outstanding requests; power of 2, 1..8.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `redirect_valid`  in  1  branch/jump redirect; has priority over all other events.
- `redirect_pc`  in  XLEN  redirect target; bits [1:0] ignored (treated as 0).
- `stall`  in  1  hazard hold; blocks new requests only.
- `req_valid`  out  1  fetch request valid.
- `req_ready`  in  1  bus accepts request.
- `req_addr`  out  ADDR_W  request byte address.
- `rsp_valid`  in  1  response valid; responses return in request order, never back-pressured.
- `rsp_data`  in  64  response doubleword.
- `ds_valid`  out  1  queue head valid.
- `ds_ready`  in  1  decode accepts head.
- `ds_inst`  out  32  head instruction; 32'h13 when `ds_valid`=0.
- `ds_pc`  out  XLEN  head PC; 0 when `ds_valid`=0.

## Operation
- State:
  - `fetch_pc`.
  - Tag FIFO (depth `MAX_OUT`) holding the PC of each accepted request.
  - Fetch queue (depth `FQ_DEPTH`) of {inst, pc}.
  - `inflight` counter (0..`MAX_OUT`).
  - `drop_cnt` counter (0..`MAX_OUT`).
- `live = inflight - drop_cnt`.
- `req_valid = !rst && !stall && !redirect_valid && inflight < MAX_OUT && fq_count + live < FQ_DEPTH`.
- Request handshake (`req_valid && req_ready`):
  - push `fetch_pc` into the tag FIFO;
  - `fetch_pc += 4`;
  - `inflight++`.
- Response (`rsp_valid`):
  - pop the tag FIFO and decrement `inflight`;
  - if `drop_cnt>0` or `redirect_valid`: discard the data and decrement `drop_cnt` if nonzero;
  - otherwise push {inst, tag_pc} into the fetch queue, with inst = tag_pc[2] ? rsp_data[63:32] : rsp_data[31:0].
- The credit rule guarantees the fetch-queue push never overflows; an overflow is an assertion failure.
- Decode pop: `ds_valid && ds_ready`.
- Redirect (`redirect_valid`=1 at an edge):
  - `fetch_pc <= {redirect_pc[XLEN-1:2],2'b0}`;
  - fetch queue flushed (any same-cycle pop or push is void);
  - `drop_cnt <= inflight_next`, i.e. every request still outstanding after this edge is dropped;
  - the tag FIFO is not flushed, because tags stay aligned with bus responses.
- Back-to-back redirects: the latest target wins and `drop_cnt` is recomputed each time.
- `stall` does not affect the fetch queue or response acceptance.

## Timing
- Reset: at the first edge with `rst`=1, all of the following hold:
  - `fetch_pc=RESET_PC`;
  - queue, tag FIFO, `inflight` and `drop_cnt` all 0;
  - `req_valid=0`, `ds_valid=0`, `ds_inst=32'h13`, `ds_pc=0`.
- First request: `req_valid` rises in the first cycle with `rst`=0.
- `rst` asserted mid-operation clears everything at that edge. Responses to pre-reset requests must not arrive after reset; the bus owns that guarantee.
- Latency:
  - request accepted in cycle N → response no earlier than N+1;
  - response in cycle M → `ds_valid` in M+1 (registered queue, no bypass).
- Throughput: one instruction per cycle when `MAX_OUT≥2`, `req_ready`=1 and 1-cycle responses.
- `req_valid` depends combinationally on `stall` and `redirect_valid`. `ds_*` are driven from registers only.
- Once raised, `req_valid` with a stable `req_addr` is not required to hold; the bus samples on handshake only.

## Structure
- Shared package/define file:
  - `NOP_INST` = 32'h13;
  - default `RESET_PC`.
- Sub-module `ysyx_22040759_sync_fifo`:
  - parametrised by width and depth;
  - synchronous `flush` input;
  - `count`, `full` and `empty` outputs.
- It is instantiated twice: as the tag FIFO (width XLEN, depth `MAX_OUT`) and as the fetch queue (width 32+XLEN, depth `FQ_DEPTH`).
- Counters and `fetch_pc` live in the top module.

## Test plan
- Reset then `req_ready`=1, with a 1-cycle response returning {32'h00000093, 32'h00000013} for 0x80000000 → `req_addr` 0x80000000, 0x80000004…; `ds_inst` 0x13 @pc 0x80000000, then 0x93 @pc 0x80000004, one per cycle.
- `ds_ready`=0 with defaults → exactly 4 responses queued, `req_valid` drops, `inflight`=0. Releasing `ds_ready` drains 4 entries in order, then fetching resumes.
- 2 requests outstanding, `redirect_valid` with `redirect_pc`=0x80001003 → both responses discarded, queue empty, next `req_addr`=0x80001000, first `ds_pc`=0x80001000.
- Redirect in the same cycle as `rsp_valid` and a queue pop → response discarded, queue empty next cycle, `drop_cnt` = remaining `inflight`.
- `stall`=1 for 5 cycles with 1 request outstanding → no new requests, the outstanding response still enqueued and delivered.
- `rst` pulsed while 2 requests are outstanding and the queue holds 3 entries → next cycle `ds_valid`=0, `ds_inst`=0x13, `req_addr`=0x80000000.
